// File: rtl/beat_detector.sv
// rtl/beat_detector.sv - adaptive-threshold beat detector on filtered samples
module beat_detector #(
  parameter int WIDTH    = 10,
  parameter int PERIOD_W = 16,
  parameter int HYST     = 16,
  parameter int MIN_GAP  = 50,
  parameter int DECAY    = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [WIDTH-1:0]    sample,
  output logic                beat,
  output logic                period_valid,
  output logic [PERIOD_W-1:0] period,
  output logic [WIDTH-1:0]    peak_level,
  output logic [WIDTH-1:0]    threshold
);

  // Threshold arithmetic runs two bits wider so thr+HYST never wraps before clamping.
  localparam int EW  = WIDTH + 2;
  localparam int DCW = (DECAY > 1) ? $clog2(DECAY) : 1;

  localparam logic [EW-1:0]       SMAX_E     = EW'((1 << WIDTH) - 1);
  localparam logic [EW-1:0]       HYST_E     = EW'(HYST);
  localparam logic [PERIOD_W-1:0] GAP_MAX    = '1;
  localparam logic [PERIOD_W:0]   MIN_GAP_E  = (PERIOD_W + 1)'(MIN_GAP);
  localparam logic [DCW-1:0]      DECAY_LAST = DCW'(DECAY - 1);

  typedef enum logic [1:0] {WAIT_LOW, ARMED, HIGH} state_t;

  state_t              state;
  logic [WIDTH-1:0]    max_trk;
  logic [WIDTH-1:0]    min_trk;
  logic [WIDTH-1:0]    peak_run;
  logic [PERIOD_W-1:0] gap_cnt;
  logic [DCW-1:0]      decay_cnt;
  logic                have_prev;

  logic [EW-1:0]       sum_e;
  logic [EW-1:0]       thr_e;
  logic [EW-1:0]       hi_raw_e;
  logic [EW-1:0]       thr_hi_e;
  logic [EW-1:0]       thr_lo_e;
  logic [EW-1:0]       sample_e;
  logic                above;
  logic                below;
  logic [PERIOD_W:0]   gap_inc;
  logic                gap_ok;
  logic                gap_sat;
  logic [PERIOD_W-1:0] period_sat;
  logic                fire;
  logic                decay_tick;
  logic [WIDTH-1:0]    peak_next;

  // Thresholds come from the tracker values held before this sample updates them.
  assign sum_e    = EW'(max_trk) + EW'(min_trk);
  assign thr_e    = sum_e >> 1;
  assign hi_raw_e = thr_e + HYST_E;
  assign thr_hi_e = (hi_raw_e > SMAX_E) ? SMAX_E : hi_raw_e;
  assign thr_lo_e = (thr_e > HYST_E) ? (thr_e - HYST_E) : '0;
  assign sample_e = EW'(sample);
  assign above    = sample_e > thr_hi_e;
  assign below    = sample_e < thr_lo_e;

  // gap_inc is the number of samples since the last beat, counting this one.
  assign gap_inc    = {1'b0, gap_cnt} + (PERIOD_W + 1)'(1);
  assign gap_ok     = gap_inc >= MIN_GAP_E;
  assign gap_sat    = gap_inc >= {1'b0, GAP_MAX};
  assign period_sat = gap_inc[PERIOD_W] ? GAP_MAX : gap_inc[PERIOD_W-1:0];

  assign fire       = (state == ARMED) && above && gap_ok;
  assign decay_tick = decay_cnt == DECAY_LAST;
  assign peak_next  = (sample > peak_run) ? sample : peak_run;

  // Min/max trackers: jump to new extremes, otherwise creep toward each other on decay ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      max_trk   <= '0;
      min_trk   <= '1;
      decay_cnt <= '0;
      threshold <= '0;
    end else if (sample_valid) begin
      threshold <= thr_e[WIDTH-1:0];
      decay_cnt <= decay_tick ? '0 : decay_cnt + DCW'(1);
      if (sample > max_trk)
        max_trk <= sample;
      else if (decay_tick && (max_trk > min_trk))
        max_trk <= max_trk - WIDTH'(1);
      if (sample < min_trk)
        min_trk <= sample;
      else if (decay_tick && (min_trk < max_trk))
        min_trk <= min_trk + WIDTH'(1);
    end
  end

  // Crossing FSM with refractory gap counter; beat/period_valid are single-cycle pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= WAIT_LOW;
      gap_cnt      <= '0;
      have_prev    <= 1'b0;
      peak_run     <= '0;
      beat         <= 1'b0;
      period_valid <= 1'b0;
      period       <= '0;
      peak_level   <= '0;
    end else begin
      beat         <= 1'b0;
      period_valid <= 1'b0;
      if (sample_valid) begin
        if (fire) begin
          gap_cnt   <= '0;
          have_prev <= 1'b1;
        end else begin
          gap_cnt <= gap_sat ? GAP_MAX : gap_inc[PERIOD_W-1:0];
          // A stale reference beat would give a bogus period, so forget it.
          if (gap_sat)
            have_prev <= 1'b0;
        end
        case (state)
          WAIT_LOW: begin
            if (below)
              state <= ARMED;
          end
          ARMED: begin
            if (fire) begin
              state    <= HIGH;
              beat     <= 1'b1;
              peak_run <= sample;
              if (have_prev) begin
                period       <= period_sat;
                period_valid <= 1'b1;
              end
            end
          end
          HIGH: begin
            peak_run <= peak_next;
            if (below) begin
              state      <= ARMED;
              peak_level <= peak_next;
            end
          end
          default: state <= WAIT_LOW;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_beat_detector.sv
// tb/tb_beat_detector.sv - scoreboard bench for beat_detector
`timescale 1ns/1ps
module tb_beat_detector;

  localparam int HYST    = 16;
  localparam int MIN_GAP = 50;
  localparam int DECAY   = 64;
  localparam int SMAX    = 1023;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, sv, reset2, sv2;
  logic [9:0] smp, smp2;
  logic       beat1, pv1, beat2, pv2;
  logic [15:0] per1;
  logic [7:0]  per2;
  logic [9:0]  peak1, thr1, peak2, thr2;

  beat_detector dut1 (
    .clk(clk), .reset(reset), .sample_valid(sv), .sample(smp),
    .beat(beat1), .period_valid(pv1), .period(per1),
    .peak_level(peak1), .threshold(thr1)
  );

  beat_detector #(.PERIOD_W(8)) dut2 (
    .clk(clk), .reset(reset2), .sample_valid(sv2), .sample(smp2),
    .beat(beat2), .period_valid(pv2), .period(per2),
    .peak_level(peak2), .threshold(thr2)
  );

  typedef struct {
    int mx, mn, gap, dc, hp, st, pr, period, peak, thr;
    logic beat, pv;
  } model_t;

  typedef struct {
    logic        beat;
    logic        pv;
    logic [15:0] period;
    logic [9:0]  peak;
    logic [9:0]  thr;
  } exp_t;

  model_t m1, m2;
  exp_t   q1[$], q2[$];
  int     log1[$], log2[$];
  int     n_cmp, n_fail;
  bit     mon_en, v1, v2;
  exp_t   em1, em2;

  function automatic void model_reset(output model_t m);
    m.mx = 0; m.mn = SMAX; m.gap = 0; m.dc = 0; m.hp = 0; m.st = 0;
    m.pr = 0; m.period = 0; m.peak = 0; m.thr = 0; m.beat = 0; m.pv = 0;
  endfunction

  // Reference behaviour for one valid sample; st 0=wait-low 1=armed 2=high.
  function automatic void model_step(inout model_t m, input int s, input int gmax);
    int thr, hi, lo, nmx, nmn;
    bit tick, fire;
    thr  = (m.mx + m.mn) / 2;
    hi   = (thr + HYST > SMAX) ? SMAX : thr + HYST;
    lo   = (thr > HYST) ? thr - HYST : 0;
    tick = (m.dc == DECAY - 1);
    fire = 0;
    m.beat = 0; m.pv = 0; m.thr = thr;
    case (m.st)
      0: if (s < lo) m.st = 1;
      1: if (s > hi && m.gap + 1 >= MIN_GAP) begin
           fire = 1; m.beat = 1; m.st = 2; m.pr = s;
           if (m.hp != 0) begin
             m.pv = 1;
             m.period = (m.gap + 1 > gmax) ? gmax : m.gap + 1;
           end
         end
      default: begin
        if (s > m.pr) m.pr = s;
        if (s < lo) begin m.st = 1; m.peak = m.pr; end
      end
    endcase
    if (fire) begin
      m.gap = 0; m.hp = 1;
    end else begin
      m.gap = (m.gap + 1 >= gmax) ? gmax : m.gap + 1;
      if (m.gap == gmax) m.hp = 0;
    end
    nmx = (s > m.mx) ? s : ((tick && m.mx > m.mn) ? m.mx - 1 : m.mx);
    nmn = (s < m.mn) ? s : ((tick && m.mn < m.mx) ? m.mn + 1 : m.mn);
    m.mx = nmx; m.mn = nmn;
    m.dc = tick ? 0 : m.dc + 1;
  endfunction

  task automatic send1(input int s, input int idle);
    exp_t e;
    sv = 1'b1; smp = 10'(s);
    model_step(m1, s, 65535);
    e.beat = m1.beat; e.pv = m1.pv; e.period = 16'(m1.period);
    e.peak = 10'(m1.peak); e.thr = 10'(m1.thr);
    q1.push_back(e);
    @(posedge clk); #2;
    sv = 1'b0;
    repeat (idle) begin @(posedge clk); #2; end
  endtask

  task automatic send2(input int s);
    exp_t e;
    sv2 = 1'b1; smp2 = 10'(s);
    model_step(m2, s, 255);
    e.beat = m2.beat; e.pv = m2.pv; e.period = 16'(m2.period);
    e.peak = 10'(m2.peak); e.thr = 10'(m2.thr);
    q2.push_back(e);
    @(posedge clk); #2;
    sv2 = 1'b0;
  endtask

  task automatic do_reset1();
    reset = 1'b1; sv = 1'b0;
    repeat (2) begin @(posedge clk); #2; end
    reset = 1'b0;
    model_reset(m1);
  endtask

  // Scoreboard monitor: every valid sample's registered result is popped and compared.
  initial begin
    forever begin
      @(posedge clk);
      v1 = sv && !reset;
      v2 = sv2 && !reset2;
      #1;
      if (mon_en) begin
        n_cmp++;
        if (v1) begin
          if (q1.size() == 0) begin
            n_fail++; $display("FAIL sb1_underflow: output cycle with no expected entry");
          end else begin
            em1 = q1.pop_front();
            if ({beat1, pv1, per1, peak1, thr1} !== {em1.beat, em1.pv, em1.period, em1.peak, em1.thr}) begin
              n_fail++;
              $display("FAIL sb1_sample: got beat=%0b pv=%0b period=%0d peak=%0d thr=%0d want beat=%0b pv=%0b period=%0d peak=%0d thr=%0d",
                       beat1, pv1, per1, peak1, thr1, em1.beat, em1.pv, em1.period, em1.peak, em1.thr);
            end
          end
          if (beat1 === 1'b1) log1.push_back(pv1 ? int'(per1) : -1);
        end else if (beat1 !== 1'b0 || pv1 !== 1'b0) begin
          n_fail++; $display("FAIL idle1_pulse: got beat=%0b pv=%0b want 0 0", beat1, pv1);
        end
        n_cmp++;
        if (v2) begin
          if (q2.size() == 0) begin
            n_fail++; $display("FAIL sb2_underflow: output cycle with no expected entry");
          end else begin
            em2 = q2.pop_front();
            if ({beat2, pv2, 8'd0, per2, peak2, thr2} !== {em2.beat, em2.pv, em2.period, em2.peak, em2.thr}) begin
              n_fail++;
              $display("FAIL sb2_sample: got beat=%0b pv=%0b period=%0d peak=%0d thr=%0d want beat=%0b pv=%0b period=%0d peak=%0d thr=%0d",
                       beat2, pv2, per2, peak2, thr2, em2.beat, em2.pv, em2.period, em2.peak, em2.thr);
            end
          end
          if (beat2 === 1'b1) log2.push_back(pv2 ? int'(per2) : -1);
        end else if (beat2 !== 1'b0 || pv2 !== 1'b0) begin
          n_fail++; $display("FAIL idle2_pulse: got beat=%0b pv=%0b want 0 0", beat2, pv2);
        end
      end
    end
  end

  task automatic test_reset();
    int nb;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sv = 1'($urandom); smp = 10'($urandom);
      @(posedge clk); #2;
    end
    n_cmp++;
    if ({beat1, pv1, per1, peak1, thr1} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got beat=%0b pv=%0b period=%0d peak=%0d thr=%0d want all 0", beat1, pv1, per1, peak1, thr1);
    end
    reset = 1'b0; sv = 1'b0;
    model_reset(m1);
    nb = log1.size();
    send1(900, 3);
    n_cmp++;
    if (log1.size() != nb) begin
      n_fail++; $display("FAIL reset_first_sample: got %0d beats want 0", log1.size() - nb);
    end
  endtask

  task automatic test_square(input int idle_min, input int idle_max);
    int nb, want;
    do_reset1();
    nb = log1.size();
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 50; i++) send1(100, int'($urandom_range(idle_max, idle_min)));
      for (int i = 0; i < 50; i++) send1(900, int'($urandom_range(idle_max, idle_min)));
    end
    n_cmp++;
    if (log1.size() - nb != 5) begin
      n_fail++; $display("FAIL square_beats: got %0d want 5", log1.size() - nb);
    end
    for (int k = 0; k < 5 && nb + k < log1.size(); k++) begin
      want = (k == 0) ? -1 : 100;
      n_cmp++;
      if (log1[nb + k] != want) begin
        n_fail++; $display("FAIL square_period[%0d]: got %0d want %0d (-1 = no period_valid)", k, log1[nb + k], want);
      end
    end
    n_cmp++;
    if (peak1 !== 10'd900) begin
      n_fail++; $display("FAIL square_peak: got %0d want 900", peak1);
    end
    n_cmp++;
    if (thr1 < 10'd499 || thr1 > 10'd501) begin
      n_fail++; $display("FAIL square_threshold: got %0d want 500 +/-1", thr1);
    end
  endtask

  task automatic test_refractory();
    int nb;
    do_reset1();
    nb = log1.size();
    repeat (50) send1(100, 0);
    send1(900, 0);
    repeat (9) send1(900, 0);
    repeat (10) send1(100, 0);
    send1(900, 0);
    n_cmp++;
    if (log1.size() - nb != 1) begin
      n_fail++; $display("FAIL refractory_gap20: got %0d beats want 1", log1.size() - nb);
    end
    repeat (29) send1(100, 0);
    send1(900, 0);
    n_cmp++;
    if (log1.size() - nb != 2) begin
      n_fail++; $display("FAIL refractory_gap50_beat: got %0d beats want 2", log1.size() - nb);
    end else begin
      n_cmp++;
      if (log1[log1.size() - 1] != 50) begin
        n_fail++; $display("FAIL refractory_gap50_period: got %0d want 50", log1[log1.size() - 1]);
      end
    end
  endtask

  task automatic test_hysteresis();
    int nb;
    do_reset1();
    nb = log1.size();
    repeat (50) send1(100, 0);
    send1(900, 0);
    repeat (49) send1(900, 0);
    send1(100, 0);
    for (int i = 0; i < 200; i++) send1((i % 2 == 0) ? 495 : 515, 0);
    n_cmp++;
    if (log1.size() - nb != 1) begin
      n_fail++; $display("FAIL hyst_band: got %0d beats want 1", log1.size() - nb);
    end
    n_cmp++;
    if (thr1 < 10'd499 || thr1 > 10'd500) begin
      n_fail++; $display("FAIL hyst_threshold: got %0d want 499..500", thr1);
    end
    send1(517, 0);
    n_cmp++;
    if (log1.size() - nb != 2) begin
      n_fail++; $display("FAIL hyst_517_beat: got %0d beats want 2", log1.size() - nb);
    end else begin
      n_cmp++;
      if (log1[log1.size() - 1] != 251) begin
        n_fail++; $display("FAIL hyst_517_period: got %0d want 251", log1[log1.size() - 1]);
      end
    end
  endtask

  task automatic test_saturation();
    int nb;
    reset2 = 1'b1;
    repeat (2) begin @(posedge clk); #2; end
    reset2 = 1'b0;
    model_reset(m2);
    nb = log2.size();
    repeat (50) send2(100);
    send2(900);
    repeat (300) send2(100);
    send2(900);
    n_cmp++;
    if (log2.size() - nb != 2) begin
      n_fail++; $display("FAIL sat_beats: got %0d want 2", log2.size() - nb);
    end else begin
      n_cmp++;
      if (log2[nb + 1] != -1) begin
        n_fail++; $display("FAIL sat_no_period: got %0d want -1 (no period_valid)", log2[nb + 1]);
      end
    end
    repeat (99) send2(100);
    send2(900);
    n_cmp++;
    if (log2.size() - nb != 3) begin
      n_fail++; $display("FAIL sat_next_beat: got %0d beats want 3", log2.size() - nb);
    end else begin
      n_cmp++;
      if (log2[nb + 2] != 100) begin
        n_fail++; $display("FAIL sat_next_period: got %0d want 100", log2[nb + 2]);
      end
    end
  endtask

  task automatic test_reset_mid_high();
    int nb, nb2;
    do_reset1();
    nb = log1.size();
    repeat (50) send1(100, 1);
    send1(900, 1);
    repeat (5) send1(900, 1);
    reset = 1'b1; sv = 1'b1; smp = 10'd900;
    repeat (2) begin @(posedge clk); #2; end
    n_cmp++;
    if ({beat1, pv1, peak1, thr1, per1} !== 38'd0) begin
      n_fail++;
      $display("FAIL midhigh_reset: got beat=%0b pv=%0b peak=%0d thr=%0d period=%0d want all 0", beat1, pv1, peak1, thr1, per1);
    end
    reset = 1'b0; sv = 1'b0;
    model_reset(m1);
    nb2 = log1.size();
    n_cmp++;
    if (nb2 - nb != 1) begin
      n_fail++; $display("FAIL midhigh_prebeats: got %0d want 1", nb2 - nb);
    end
    repeat (60) send1(900, 1);
    n_cmp++;
    if (log1.size() != nb2) begin
      n_fail++; $display("FAIL midhigh_waitlow: got %0d beats want 0", log1.size() - nb2);
    end
    send1(100, 1);
    send1(900, 1);
    n_cmp++;
    if (log1.size() - nb2 != 1) begin
      n_fail++; $display("FAIL midhigh_rearm: got %0d beats want 1", log1.size() - nb2);
    end else begin
      n_cmp++;
      if (log1[log1.size() - 1] != -1) begin
        n_fail++; $display("FAIL midhigh_first_pv: got %0d want -1 (no period_valid)", log1[log1.size() - 1]);
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; mon_en = 1'b0;
    reset = 1'b1; reset2 = 1'b1;
    sv = 1'b0; sv2 = 1'b0; smp = '0; smp2 = '0;
    model_reset(m1); model_reset(m2);
    repeat (3) begin @(posedge clk); #2; end
    reset2 = 1'b0;
    mon_en = 1'b1;
    test_reset();
    test_square(3, 3);
    test_refractory();
    test_hysteresis();
    test_saturation();
    test_square(0, 5);
    test_reset_mid_high();
    repeat (2) begin @(posedge clk); #2; end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
